sbox_sched: RTL and testbench

Time-multiplexed S-box controller. It shares NSBOX instances of the existing combinational byte S-box between two requesters: the cipher datapath (SubBytes on a 128-bit state) and the key-expansion unit (SubWord on a 32-bit word). It arbitrates, sequences the bytes through the shared S-boxes over several cycles, and returns registered results with a one-cycle done pulse.

---
 rtl/sbox_sched.sv | 173 +++++++++++++++++
 tb/tb_sbox_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_sched.sv
// Time-multiplexed AES S-box controller: NSBOX shared byte S-boxes serve the
// 128-bit SubBytes requester and the 32-bit SubWord requester, round-robin.

module sbox_byte (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse in GF(2^8) as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    assign inv = gf_inv(a);
    assign s   = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
endmodule

// state  | meaning
// IDLE   | no job active, readies may be granted
// RUN_SB | SubBytes job stepping through 16 bytes
// RUN_SW | SubWord job stepping through 4 bytes
module sbox_sched #(
    parameter int NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sb_valid,
    output logic         sb_ready,
    input  logic [127:0] sb_in,
    output logic [127:0] sb_out,
    output logic         sb_done,
    input  logic         sw_valid,
    output logic         sw_ready,
    input  logic [31:0]  sw_in,
    output logic [31:0]  sw_out,
    output logic         sw_done,
    output logic         busy
);
    localparam int         SHIFT   = (NSBOX == 4) ? 2 : (NSBOX == 2) ? 1 : 0;
    localparam logic [3:0] SB_LAST = 4'(16 / NSBOX - 1);
    localparam logic [3:0] SW_LAST = 4'(4 / NSBOX - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN_SB = 2'd1;
    localparam logic [1:0] RUN_SW = 2'd2;

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic         last_sw;
    logic [127:0] work;
    logic [127:0] sb_res;
    logic [31:0]  sw_res;
    logic         sb_done_q;
    logic         sw_done_q;

    logic         idle;
    logic         grant_sb;
    logic         grant_sw;
    logic         last_chunk;
    logic [3:0]   base;
    logic [7:0]   sbox_s [NSBOX];

    // last_sw=0 after reset means SubWord wins the first tie.
    always_comb begin
        idle       = (state == IDLE);
        grant_sw   = idle && sw_valid && (!sb_valid || !last_sw);
        grant_sb   = idle && sb_valid && (!sw_valid || last_sw);
        base       = cnt << SHIFT;
        last_chunk = (state == RUN_SB) ? (cnt == SB_LAST) : (cnt == SW_LAST);
    end

    for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
        logic [3:0] bidx;
        assign bidx = base | 4'(g);
        sbox_byte u_sbox (
            .a (work[{bidx, 3'b000} +: 8]),
            .s (sbox_s[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_sw   <= 1'b0;
            work      <= '0;
            sb_res    <= '0;
            sw_res    <= '0;
            sb_done_q <= 1'b0;
            sw_done_q <= 1'b0;
        end else begin
            sb_done_q <= 1'b0;
            sw_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_sw) begin
                        work    <= {96'b0, sw_in};
                        sw_res  <= '0;
                        last_sw <= 1'b1;
                        cnt     <= 4'd0;
                        state   <= RUN_SW;
                    end else if (grant_sb) begin
                        work    <= sb_in;
                        sb_res  <= '0;
                        last_sw <= 1'b0;
                        cnt     <= 4'd0;
                        state   <= RUN_SB;
                    end
                end
                RUN_SB: begin
                    for (int i = 0; i < NSBOX; i++)
                        sb_res[{base | 4'(i), 3'b000} +: 8] <= sbox_s[i];
                    if (last_chunk) begin
                        state     <= IDLE;
                        cnt       <= 4'd0;
                        sb_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RUN_SW: begin
                    for (int i = 0; i < NSBOX; i++)
                        sw_res[{base[1:0] | 2'(i), 3'b000} +: 8] <= sbox_s[i];
                    if (last_chunk) begin
                        state     <= IDLE;
                        cnt       <= 4'd0;
                        sw_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign sb_ready = grant_sb;
    assign sw_ready = grant_sw;
    assign sb_out   = sb_res;
    assign sw_out   = sw_res;
    assign sb_done  = sb_done_q;
    assign sw_done  = sw_done_q;
    assign busy     = !idle;
endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched: three instances (NSBOX=4,2,1) share stimulus;
// expected results come from a FIPS-197 S-box lookup table.

module tb_sbox_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         sb_valid, sw_valid;
    logic [127:0] sb_in;
    logic [31:0]  sw_in;

    logic         sb_ready4, sb_done4, sw_ready4, sw_done4, busy4;
    logic [127:0] sb_out4;
    logic [31:0]  sw_out4;
    logic         sb_ready2, sb_done2, sw_ready2, sw_done2, busy2;
    logic [127:0] sb_out2;
    logic [31:0]  sw_out2;
    logic         sb_ready1, sb_done1, sw_ready1, sw_done1, busy1;
    logic [127:0] sb_out1;
    logic [31:0]  sw_out1;

    int checks   = 0;
    int failures = 0;

    logic [127:0] sb_q[$];
    logic [31:0]  sw_q[$];

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    sbox_sched #(.NSBOX(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .sb_valid(sb_valid), .sb_ready(sb_ready4), .sb_in(sb_in), .sb_out(sb_out4), .sb_done(sb_done4),
        .sw_valid(sw_valid), .sw_ready(sw_ready4), .sw_in(sw_in), .sw_out(sw_out4), .sw_done(sw_done4),
        .busy(busy4)
    );
    sbox_sched #(.NSBOX(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .sb_valid(sb_valid), .sb_ready(sb_ready2), .sb_in(sb_in), .sb_out(sb_out2), .sb_done(sb_done2),
        .sw_valid(sw_valid), .sw_ready(sw_ready2), .sw_in(sw_in), .sw_out(sw_out2), .sw_done(sw_done2),
        .busy(busy2)
    );
    sbox_sched #(.NSBOX(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .sb_valid(sb_valid), .sb_ready(sb_ready1), .sb_in(sb_in), .sb_out(sb_out1), .sb_done(sb_done1),
        .sw_valid(sw_valid), .sw_ready(sw_ready1), .sw_in(sw_in), .sw_out(sw_out1), .sw_done(sw_done1),
        .busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_sw(input logic [31:0] x);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_tab[x[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] exp_sb(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_tab[x[8*k +: 8]];
        return r;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        sb_valid = 1'b0;
        sw_valid = 1'b0;
        sb_in    = '0;
        sw_in    = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns the number of edges from the call point to the done cycle, or -1.
    task automatic wait_done(input int which, output int lat);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if ((which == 0 && sb_done4) || (which == 1 && sw_done4)) lat = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sb_valid = 1'b0; sw_valid = 1'b0; sb_in = '0; sw_in = '0;
        #3;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy4); end
        checks++; if (sb_out4 !== 128'h0) begin failures++; $display("FAIL reset_sb_out got=%h exp=0", sb_out4); end
        checks++; if (sw_out4 !== 32'h0) begin failures++; $display("FAIL reset_sw_out got=%h exp=0", sw_out4); end
        checks++; if ({sb_done4, sw_done4, sb_ready4, sw_ready4} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {sb_done4, sw_done4, sb_ready4, sw_ready4});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_subword();
        int lat4, lat2, lat1;
        logic [31:0] e;
        do_reset();
        sw_in = 32'hcf4f3c09; sw_valid = 1'b1;
        @(negedge clk);
        checks++; if ({sw_ready4, sw_ready2, sw_ready1, sb_ready4} !== 4'b1110) begin
            failures++; $display("FAIL sw_ready got=%b exp=1110", {sw_ready4, sw_ready2, sw_ready1, sb_ready4});
        end
        repeat (3) sw_q.push_back(exp_sw(sw_in));
        @(posedge clk);
        #1 sw_valid = 1'b0;
        checks++; if ({busy4, busy2, busy1} !== 3'b111) begin
            failures++; $display("FAIL sw_busy got=%b exp=111", {busy4, busy2, busy1});
        end
        lat4 = -1; lat2 = -1; lat1 = -1;
        for (int c = 1; c <= 20 && lat1 < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat4 > 0 && c == lat4 + 1) begin
                checks++; if (sw_done4 !== 1'b0) begin failures++; $display("FAIL sw_pulse got=%b exp=0", sw_done4); end
            end
            if (sw_done4 && lat4 < 0) begin
                lat4 = c; e = sw_q.pop_front();
                checks++; if (sw_out4 !== e) begin failures++; $display("FAIL sw_out4 got=%h exp=%h", sw_out4, e); end
            end
            if (sw_done2 && lat2 < 0) begin
                lat2 = c; e = sw_q.pop_front();
                checks++; if (sw_out2 !== e) begin failures++; $display("FAIL sw_out2 got=%h exp=%h", sw_out2, e); end
            end
            if (sw_done1 && lat1 < 0) begin
                lat1 = c; e = sw_q.pop_front();
                checks++; if (sw_out1 !== e) begin failures++; $display("FAIL sw_out1 got=%h exp=%h", sw_out1, e); end
            end
        end
        checks++; if (lat4 != 1 || lat2 != 2 || lat1 != 4) begin
            failures++; $display("FAIL sw_latency got=%0d/%0d/%0d exp=1/2/4", lat4, lat2, lat1);
        end
        checks++; if (sw_out4 !== 32'h8a84eb01) begin failures++; $display("FAIL sw_hold got=%h exp=8a84eb01", sw_out4); end
    endtask

    task automatic test_sb_nsbox();
        int lat4, lat2, lat1;
        logic [127:0] e;
        do_reset();
        sb_in = 128'h00112233445566778899aabbccddeeff; sb_valid = 1'b1;
        @(negedge clk);
        checks++; if ({sb_ready4, sb_ready2, sb_ready1, sw_ready4} !== 4'b1110) begin
            failures++; $display("FAIL sb_ready got=%b exp=1110", {sb_ready4, sb_ready2, sb_ready1, sw_ready4});
        end
        repeat (3) sb_q.push_back(exp_sb(sb_in));
        @(posedge clk);
        #1 sb_valid = 1'b0;
        lat4 = -1; lat2 = -1; lat1 = -1;
        for (int c = 1; c <= 40 && lat1 < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (sb_done4 && lat4 < 0) begin
                lat4 = c; e = sb_q.pop_front();
                checks++; if (sb_out4 !== e) begin failures++; $display("FAIL sb_out4 got=%h exp=%h", sb_out4, e); end
            end
            if (sb_done2 && lat2 < 0) begin
                lat2 = c; e = sb_q.pop_front();
                checks++; if (sb_out2 !== e) begin failures++; $display("FAIL sb_out2 got=%h exp=%h", sb_out2, e); end
            end
            if (sb_done1 && lat1 < 0) begin
                lat1 = c; e = sb_q.pop_front();
                checks++; if (sb_out1 !== e) begin failures++; $display("FAIL sb_out1 got=%h exp=%h", sb_out1, e); end
            end
        end
        checks++; if (lat4 != 4 || lat2 != 8 || lat1 != 16) begin
            failures++; $display("FAIL sb_latency got=%0d/%0d/%0d exp=4/8/16", lat4, lat2, lat1);
        end
    endtask

    task automatic test_arbitration();
        int grants = 0;
        bit active = 1'b0;
        bit accept;
        bit took_sw;
        bit exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [127:0] es;
        logic [31:0]  ew;
        do_reset();
        sb_in = 128'h0123456789abcdeffedcba9876543210; sw_in = 32'h13579bdf;
        sb_valid = 1'b1; sw_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && (grants < 4 || active); cyc++) begin
            @(negedge clk);
            accept = 1'b0;
            if (sb_done4) begin
                active = 1'b0;
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL arb_sb_unexpected got=%h", sb_out4); end
                else begin
                    es = sb_q.pop_front();
                    if (sb_out4 !== es) begin failures++; $display("FAIL arb_sb_out got=%h exp=%h", sb_out4, es); end
                end
            end
            if (sw_done4) begin
                active = 1'b0;
                checks++;
                if (sw_q.size() == 0) begin failures++; $display("FAIL arb_sw_unexpected got=%h", sw_out4); end
                else begin
                    ew = sw_q.pop_front();
                    if (sw_out4 !== ew) begin failures++; $display("FAIL arb_sw_out got=%h exp=%h", sw_out4, ew); end
                end
            end
            checks++; if (busy4 !== active) begin failures++; $display("FAIL arb_busy got=%b exp=%b", busy4, active); end
            checks++; if (sb_ready4 && sw_ready4) begin failures++; $display("FAIL arb_both_ready got=11 exp=not 11"); end
            if ((sb_ready4 || sw_ready4) && grants < 4) begin
                took_sw = sw_ready4;
                checks++; if (took_sw !== exp_order[grants]) begin
                    failures++; $display("FAIL arb_order grant=%0d got_sw=%b exp_sw=%b", grants, took_sw, exp_order[grants]);
                end
                if (took_sw) sw_q.push_back(exp_sw(sw_in));
                else         sb_q.push_back(exp_sb(sb_in));
                grants++;
                accept = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accept) begin
                active = 1'b1;
                if (took_sw) sw_in = sw_in + 32'h11111111;
                else         sb_in = ~sb_in;
            end
            if (grants == 4) begin sb_valid = 1'b0; sw_valid = 1'b0; end
        end
        checks++; if (grants != 4 || active) begin
            failures++; $display("FAIL arb_timeout grants=%0d exp=4 active=%b", grants, active);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] e;
        do_reset();
        sb_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0; sb_valid = 1'b1;
        @(negedge clk);
        sb_q.push_back(exp_sb(sb_in));
        @(posedge clk);
        #1 sb_in = {16{8'h53}};
        wait_done(0, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=4", lat); end
        e = sb_q.pop_front();
        checks++; if (sb_out4 !== e) begin failures++; $display("FAIL b2b_out1 got=%h exp=%h", sb_out4, e); end
        checks++; if ({sb_ready4, busy4} !== 2'b10) begin
            failures++; $display("FAIL b2b_ready_in_done got=%b exp=10", {sb_ready4, busy4});
        end
        sb_q.push_back(exp_sb(sb_in));
        @(posedge clk);
        #1 sb_valid = 1'b0;
        checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL b2b_no_gap got=%b exp=1", busy4); end
        wait_done(0, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=4", lat); end
        e = sb_q.pop_front();
        checks++; if (sb_out4 !== e) begin failures++; $display("FAIL b2b_out2 got=%h exp=%h", sb_out4, e); end
        checks++; if (sb_out4 !== {16{8'hed}}) begin failures++; $display("FAIL b2b_ed got=%h exp=all ed", sb_out4); end
    endtask

    task automatic test_reset_midjob();
        int lat;
        bit saw_done;
        logic [127:0] partial;
        logic [31:0]  e;
        do_reset();
        sb_in = 128'h00112233445566778899aabbccddeeff; sb_valid = 1'b1;
        @(posedge clk);
        #1 sb_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        partial = exp_sb(sb_in);
        partial[127:32] = '0;
        checks++; if (sb_out4 !== partial) begin failures++; $display("FAIL mid_partial got=%h exp=%h", sb_out4, partial); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy4, sb_done4} !== 2'b00 || sb_out4 !== 128'h0) begin
            failures++; $display("FAIL mid_reset busy=%b done=%b out=%h exp=0", busy4, sb_done4, sb_out4);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (sb_done4) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL mid_no_done got=1 exp=0"); end
        sw_in = 32'h0053ff00; sw_valid = 1'b1;
        sw_q.push_back(exp_sw(sw_in));
        @(posedge clk);
        #1 sw_valid = 1'b0;
        wait_done(1, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL mid_sw_lat got=%0d exp=1", lat); end
        e = sw_q.pop_front();
        checks++; if (sw_out4 !== e) begin failures++; $display("FAIL mid_sw_out got=%h exp=%h", sw_out4, e); end
    endtask

    task automatic test_all_bytes();
        int lat;
        logic [31:0] e;
        do_reset();
        for (int w = 0; w < 64; w++) begin
            sw_in = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
            sw_valid = 1'b1;
            sw_q.push_back(exp_sw(sw_in));
            @(posedge clk);
            #1 sw_valid = 1'b0;
            wait_done(1, lat);
            e = sw_q.pop_front();
            checks++;
            if (lat != 1 || sw_out4 !== e) begin
                failures++; $display("FAIL all_bytes w=%0d got=%h exp=%h lat=%0d", w, sw_out4, e, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_sb_nsbox();
        test_arbitration();
        test_back_to_back();
        test_reset_midjob();
        test_all_bytes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
